// File: rtl/cache_ram_arbiter.sv
// cache_ram_arbiter
// Shares one main RAM between two direct-mapped caches. Requester 0 is the
// instruction cache and requester 1 is the data cache. Level-held fetch/flush
// requests are serialised onto a single RAM port with a fixed latency. The
// served requester gets a one-cycle ack; for fetches, its read data is valid
// in that same cycle.
//
// Ports
//   clka, rsta              clock, asynchronous active-high reset
//   fetchN, flushN          read / write request from requester N, held until ack
//   addrN, wdataN           request address and flush data from requester N
//   fetch_ackN, flush_ackN  one-cycle completion pulses to requester N
//   rdataN                  last word fetched for requester N
//   ram_en, ram_we          RAM strobe (one cycle per transaction), write enable
//   ram_addr, ram_din       RAM address and write data, held between transactions
//   ram_dout                RAM read data
//   busy                    high whenever the arbiter is not idle
module cache_ram_arbiter #(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     fetch0,
  input  logic                     fetch1,
  input  logic                     flush0,
  input  logic                     flush1,
  input  logic [ADDRESS_SPACE-1:0] addr0,
  input  logic [ADDRESS_SPACE-1:0] addr1,
  input  logic [DATA_SIZE-1:0]     wdata0,
  input  logic [DATA_SIZE-1:0]     wdata1,
  output logic                     fetch_ack0,
  output logic                     fetch_ack1,
  output logic                     flush_ack0,
  output logic                     flush_ack1,
  output logic [DATA_SIZE-1:0]     rdata0,
  output logic [DATA_SIZE-1:0]     rdata1,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDRESS_SPACE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0]     ram_din,
  input  logic [DATA_SIZE-1:0]     ram_dout,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Counter value in the final ACCESS cycle (ACCESS lasts LATENCY+1 cycles).
  localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'(READ_LATENCY);
  localparam logic [CNT_WIDTH-1:0] WR_LAST = CNT_WIDTH'(WRITE_LATENCY);

  state_t                   state_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic                     grant_q;
  logic                     is_write_q;
  logic                     last_grant_q;
  logic                     ram_en_q;
  logic                     ram_we_q;
  logic [ADDRESS_SPACE-1:0] ram_addr_q;
  logic [DATA_SIZE-1:0]     ram_din_q;
  logic [DATA_SIZE-1:0]     rdata0_q;
  logic [DATA_SIZE-1:0]     rdata1_q;
  logic                     fetch_ack0_q;
  logic                     fetch_ack1_q;
  logic                     flush_ack0_q;
  logic                     flush_ack1_q;

  logic                     active0_d;
  logic                     active1_d;
  logic                     grant_d;
  logic                     access_done_d;

  // Both active: grant the requester that was not served last time.
  always_comb begin
    active0_d     = fetch0 | flush0;
    active1_d     = fetch1 | flush1;
    grant_d       = active1_d & (~active0_d | ~last_grant_q);
    access_done_d = (cnt_q == (is_write_q ? WR_LAST : RD_LAST));
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      is_write_q   <= 1'b0;
      last_grant_q <= 1'b1;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      fetch_ack0_q <= 1'b0;
      fetch_ack1_q <= 1'b0;
      flush_ack0_q <= 1'b0;
      flush_ack1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (active0_d || active1_d) begin
            // A flush wins over a fetch raised together by the same requester.
            grant_q    <= grant_d;
            ram_addr_q <= grant_d ? addr1 : addr0;
            ram_din_q  <= grant_d ? wdata1 : wdata0;
            ram_we_q   <= grant_d ? flush1 : flush0;
            is_write_q <= grant_d ? flush1 : flush0;
            ram_en_q   <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          cnt_q    <= cnt_q + 1'b1;
          if (access_done_d) begin
            if (is_write_q) begin
              flush_ack0_q <= ~grant_q;
              flush_ack1_q <= grant_q;
            end else begin
              fetch_ack0_q <= ~grant_q;
              fetch_ack1_q <= grant_q;
              if (grant_q) rdata1_q <= ram_dout;
              else         rdata0_q <= ram_dout;
            end
            state_q <= ACK;
          end
        end
        ACK: begin
          fetch_ack0_q <= 1'b0;
          fetch_ack1_q <= 1'b0;
          flush_ack0_q <= 1'b0;
          flush_ack1_q <= 1'b0;
          last_grant_q <= grant_q;
          state_q      <= RELEASE;
        end
        RELEASE: begin
          // Dead cycle: the served cache drops its request; nothing is sampled.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch_ack0 = fetch_ack0_q;
  assign fetch_ack1 = fetch_ack1_q;
  assign flush_ack0 = flush_ack0_q;
  assign flush_ack1 = flush_ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign busy       = (state_q != IDLE);

endmodule
